// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: valid/ready input into a FIFO, LSB-first serialiser
// with optional parity, 1 or 2 stop bits and a runtime bit-period divisor.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (0) for one bit period
// DATA   | DATA_BITS data bits, LSB first
// PARITY | parity bit (only reachable when PARITY != 0)
// STOP   | STOP_BITS stop bits (1); may pop the next word on its last clock
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_WIDTH-1:0]          baud_div,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_n;
    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]  head;
    logic [DATA_BITS-1:0]  shift, shift_n;
    logic                  par_bit, par_bit_n;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [DIV_WIDTH-1:0]  baud_cnt, baud_cnt_n;
    logic [DIV_WIDTH-1:0]  div_q, div_n;
    logic                  tx_n;
    logic                  push, pop;
    logic                  bit_end;
    logic                  fifo_nonempty;

    assign in_ready      = (fifo_level != LVL_W'(FIFO_DEPTH));
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (fifo_level != '0);
    assign head          = mem[rd_ptr];
    assign bit_end       = (baud_cnt == div_q - DIV_WIDTH'(1));
    assign busy          = (state != S_IDLE) || fifo_nonempty;

    // FIFO storage: written on every accepted push, no reset needed for the data array
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy count; simultaneous push and pop keep the level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Serialiser state register; tx is registered so the line never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            par_bit  <= 1'b0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            div_q    <= '0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            shift    <= shift_n;
            par_bit  <= par_bit_n;
            bit_cnt  <= bit_cnt_n;
            baud_cnt <= baud_cnt_n;
            div_q    <= div_n;
        end
    end

    // Next-state logic: bit sequencing, baud timing and the pop decision
    always_comb begin
        state_n    = state;
        tx_n       = tx;
        shift_n    = shift;
        par_bit_n  = par_bit;
        bit_cnt_n  = bit_cnt;
        baud_cnt_n = baud_cnt;
        div_n      = div_q;
        pop        = 1'b0;

        if (state != S_IDLE) begin
            baud_cnt_n = bit_end ? '0 : baud_cnt + DIV_WIDTH'(1);
        end

        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (fifo_nonempty) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                    tx_n      = shift[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_n = '0;
                        if (PARITY != 0) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n   = S_STOP;
                    bit_cnt_n = '0;
                    tx_n      = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                        if (fifo_nonempty) begin
                            pop = 1'b1;
                        end else begin
                            state_n   = S_IDLE;
                            bit_cnt_n = '0;
                            tx_n      = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // A pop always starts a fresh frame: load the word, latch the divisor, start bit out
        if (pop) begin
            state_n    = S_START;
            shift_n    = head;
            par_bit_n  = (^head) ^ (PARITY == 1);
            div_n      = (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
            baud_cnt_n = '0;
            bit_cnt_n  = '0;
            tx_n       = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo. Instance a is 8N1 with a 16-deep FIFO;
// instances b (odd parity) and c (even parity) are 8-bit, 2 stop bits, 4-deep,
// driven in lockstep. A line receiver per instance decodes tx sample-by-sample
// against a queue of expected {word, divisor} entries.
module tb_uart_tx_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        rst_a, v_a, rdy_a, tx_a, busy_a;
    logic [15:0] div_a;
    logic [7:0]  d_a;
    logic [4:0]  lvl_a;

    logic        rst_bc, v_bc;
    logic [15:0] div_bc;
    logic [7:0]  d_bc;
    logic        rdy_b, tx_b, busy_b, rdy_c, tx_c, busy_c;
    logic [2:0]  lvl_b, lvl_c;

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] div;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int rx_starts[3];
    int rx_done[3];
    int rx_last_start[3];
    int rx_last_end[3];

    uart_tx_fifo u_a (
        .clk(clk), .reset(rst_a), .baud_div(div_a), .in_valid(v_a), .in_ready(rdy_a),
        .in_data(d_a), .tx(tx_a), .busy(busy_a), .fifo_level(lvl_a)
    );

    uart_tx_fifo #(.PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .reset(rst_bc), .baud_div(div_bc), .in_valid(v_bc), .in_ready(rdy_b),
        .in_data(d_bc), .tx(tx_b), .busy(busy_b), .fifo_level(lvl_b)
    );

    uart_tx_fifo #(.PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .clk(clk), .reset(rst_bc), .baud_div(div_bc), .in_valid(v_bc), .in_ready(rdy_c),
        .in_data(d_bc), .tx(tx_c), .busy(busy_c), .fifo_level(lvl_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input int id);
        case (id)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic rst_of(input int id);
        return (id == 0) ? rst_a : rst_bc;
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return qa.size();
            1:       return qb.size();
            default: return qc.size();
        endcase
    endfunction

    task automatic qflush(input int id);
        case (id)
            0:       qa.delete();
            1:       qb.delete();
            default: qc.delete();
        endcase
    endtask

    task automatic qpop(input int id, output exp_t e);
        case (id)
            0:       e = qa.pop_front();
            1:       e = qb.pop_front();
            default: e = qc.pop_front();
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Line receiver: every clock of every bit is compared against the expected frame
    task automatic rx_run(input int id);
        exp_t        e;
        logic [11:0] bits;
        logic [7:0]  got;
        logic        s;
        int          nb, dv, bad, b, k;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst_of(id)) begin
                qflush(id);
                continue;
            end
            if (tx_of(id) !== 1'b0) continue;
            rx_starts[id]++;
            rx_last_start[id] = cyc;
            checks++;
            assert (qsize(id) != 0) else begin
                errors++;
                $error("FAIL rx%0d_unexpected_frame observed=empty queue expected=queued word", id);
            end
            if (qsize(id) == 0) begin
                for (int w = 0; w < 200 && tx_of(id) === 1'b0; w++) @(negedge clk);
                continue;
            end
            qpop(id, e);
            dv   = int'(e.div);
            nb   = (id == 0) ? 10 : 12;
            bits = '1;
            bits[0]   = 1'b0;
            bits[8:1] = e.data;
            if (id != 0) bits[9] = (^e.data) ^ (id == 1);
            bad     = 0;
            got     = '0;
            aborted = 1'b0;
            for (int t = 0; t < nb * dv; t++) begin
                if (t != 0) begin
                    @(negedge clk);
                    if (rst_of(id)) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                s = tx_of(id);
                b = t / dv;
                k = t % dv;
                if (s !== bits[b]) bad++;
                if (b >= 1 && b <= 8 && k == dv / 2) got[b-1] = s;
            end
            if (aborted) begin
                qflush(id);
                continue;
            end
            chk($sformatf("rx%0d_bit_samples_wrong", id), bad, 0);
            chk($sformatf("rx%0d_data", id), got, e.data);
            rx_done[id]++;
            rx_last_end[id] = cyc;
        end
    endtask

    task automatic push_a(input logic [7:0] d, input int dv);
        int   t = 0;
        exp_t e;
        e.data = d;
        e.div  = 16'(dv);
        step();
        v_a = 1'b1;
        d_a = d;
        while (rdy_a !== 1'b1 && t < 5000) begin
            step();
            t++;
        end
        chk("push_a_ready", rdy_a, 1);
        qa.push_back(e);
        @(posedge clk);
        #1;
        v_a = 1'b0;
    endtask

    task automatic push_bc(input logic [7:0] d, input int dv);
        int   t = 0;
        exp_t e;
        e.data = d;
        e.div  = 16'(dv);
        step();
        v_bc = 1'b1;
        d_bc = d;
        while (rdy_b !== 1'b1 && t < 5000) begin
            step();
            t++;
        end
        chk("push_bc_ready", rdy_b, 1);
        qb.push_back(e);
        qc.push_back(e);
        @(posedge clk);
        #1;
        v_bc = 1'b0;
    endtask

    task automatic wait_done(input int id, input int n, input int budget);
        int t = 0;
        while (rx_done[id] < n && t < budget) begin
            step();
            t++;
        end
        chk($sformatf("wait_done%0d", id), rx_done[id], n);
    endtask

    task automatic wait_start(input int id, input int n, input int budget);
        int t = 0;
        while (rx_starts[id] < n && t < budget) begin
            step();
            t++;
        end
        chk($sformatf("wait_start%0d", id), rx_starts[id], n);
    endtask

    initial begin
        logic [7:0] words [6];
        exp_t e;
        int   nacc, s0, acc_cyc, el, t, end4, base;
        logic [7:0] rw;

        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        words[3] = 8'h00; words[4] = 8'h5A; words[5] = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            rx_starts[i] = 0; rx_done[i] = 0; rx_last_start[i] = 0; rx_last_end[i] = 0;
        end

        rst_a = 1'b0; rst_bc = 1'b0;
        v_a = 1'b0; d_a = '0; div_a = 16'd4;
        v_bc = 1'b0; d_bc = '0; div_bc = 16'd3;
        #2;
        rst_a = 1'b1; rst_bc = 1'b1;

        fork
            rx_run(0);
            rx_run(1);
            rx_run(2);
        join_none

        // Reset state
        step(); step();
        chk("rst_tx_a", tx_a, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_lvl_a", lvl_a, 0);
        chk("rst_rdy_a", rdy_a, 1);
        rst_a = 1'b0; rst_bc = 1'b0;
        step();
        chk("post_rst_tx_a", tx_a, 1);
        chk("post_rst_tx_b", tx_b, 1);
        chk("post_rst_lvl_b", lvl_b, 0);
        chk("post_rst_rdy_c", rdy_c, 1);

        // T1: 0xA5 at div 4, one-clock latency, 40-clock frame
        push_a(8'hA5, 4);
        step();
        chk("t1_tx_high_at_accept", tx_a, 1);
        chk("t1_lvl_after_push", lvl_a, 1);
        chk("t1_busy_after_push", busy_a, 1);
        step();
        chk("t1_start_latency", tx_a, 0);
        chk("t1_lvl_after_pop", lvl_a, 0);
        wait_done(0, 1, 100);
        chk("t1_frame_len", rx_last_end[0] - rx_last_start[0], 39);
        chk("t1_busy_last_stop_clk", busy_a, 1);
        step();
        chk("t1_busy_after_frame", busy_a, 0);

        // T2: 0x07 with odd/even parity, 2 stop bits, div 3
        push_bc(8'h07, 3);
        wait_start(1, 1, 20);
        repeat (27) step();
        chk("t2_odd_parity_bit", tx_b, 0);
        chk("t2_even_parity_bit", tx_c, 1);
        wait_done(1, 1, 100);
        chk("t2_frame_len", rx_last_end[1] - rx_last_start[1], 35);
        wait_done(2, 1, 10);

        // T3: six words with valid held into a 4-deep FIFO, div 2 (24-clock frames)
        div_bc  = 16'd2;
        base    = rx_starts[1];
        nacc    = 0;
        s0      = -1;
        acc_cyc = 0;
        t       = 0;
        step();
        while (t < 400) begin
            el = nacc - (rx_starts[1] - base);
            chk("t3_level", lvl_b, el);
            chk("t3_ready", rdy_b, (el < 4) ? 1 : 0);
            if (s0 < 0 && rx_starts[1] == base + 1) s0 = rx_last_start[1];
            if (nacc == 6) break;
            v_bc = 1'b1;
            d_bc = words[nacc];
            if (rdy_b) begin
                e.data = words[nacc];
                e.div  = 16'd2;
                qb.push_back(e);
                qc.push_back(e);
                if (nacc == 0) acc_cyc = cyc;
                step();
                nacc++;
            end else begin
                step();
            end
            t++;
        end
        v_bc = 1'b0;
        wait_done(1, 7, 1000);
        chk("t3_first_pop_at_once", s0, acc_cyc + 2);
        chk("t3_back_to_back_span", rx_last_end[1] - s0, 6 * 24 - 1);
        wait_done(2, 7, 10);
        step();
        chk("t3_lvl_end", lvl_b, 0);
        chk("t3_busy_end_b", busy_b, 0);
        chk("t3_busy_end_c", busy_c, 0);
        chk("t3_lvl_end_c", lvl_c, 0);

        // T4: divisors below 2 clamp to 2; divisor change mid-frame waits for next frame
        div_a = 16'd0;
        push_a(8'h3C, 2);
        wait_done(0, 2, 200);
        chk("t4_div0_len", rx_last_end[0] - rx_last_start[0], 19);
        div_a = 16'd1;
        push_a(8'hC3, 2);
        wait_done(0, 3, 200);
        chk("t4_div1_len", rx_last_end[0] - rx_last_start[0], 19);
        div_a = 16'd4;
        push_a(8'h5A, 4);
        push_a(8'h96, 8);
        wait_start(0, 4, 20);
        repeat (6) step();
        div_a = 16'd8;
        wait_done(0, 4, 200);
        end4 = rx_last_end[0];
        chk("t4_frame_keeps_div4", end4 - rx_last_start[0], 39);
        wait_done(0, 5, 400);
        chk("t4_no_gap", rx_last_start[0], end4 + 1);
        chk("t4_next_frame_div8", rx_last_end[0] - rx_last_start[0], 79);

        // T5: reset during data bit 3 with two words queued
        div_a = 16'd4;
        push_a(8'hF0, 4);
        push_a(8'h0F, 4);
        push_a(8'h33, 4);
        wait_start(0, 6, 20);
        t = 0;
        while ((cyc - rx_last_start[0]) != 17 && t < 100) begin
            step();
            t++;
        end
        chk("t5_pre_reset_tx", tx_a, 0);
        chk("t5_pre_reset_lvl", lvl_a, 2);
        #1;
        rst_a = 1'b1;
        #1;
        chk("t5_reset_tx", tx_a, 1);
        chk("t5_reset_lvl", lvl_a, 0);
        chk("t5_reset_busy", busy_a, 0);
        chk("t5_reset_rdy", rdy_a, 1);
        step();
        step();
        rst_a = 1'b0;
        step();
        chk("t5_post_release_tx", tx_a, 1);
        push_a(8'h81, 4);
        wait_done(0, 6, 200);
        chk("t5_clean_frame_len", rx_last_end[0] - rx_last_start[0], 39);
        step();
        chk("t5_busy_after", busy_a, 0);

        // T6: 1000 random words with random stalls at div 2
        div_a = 16'd2;
        base  = rx_done[0];
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 30)) step();
            end
            rw = 8'($urandom);
            push_a(rw, 2);
        end
        wait_done(0, base + 1000, 2000);
        chk("t6_queue_drained", qa.size(), 0);
        step();
        chk("t6_busy_end", busy_a, 0);
        chk("t6_lvl_end", lvl_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
